// File: rtl/pwm_deadtime_if.sv
// Register write/read bus shared by the PWM peripherals.
interface pwm_deadtime_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with programmable dead time, polarity and sticky fault kill.
module pwm_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_deadtime_if.slave bus,
    input  logic          pwm_in,
    input  logic          fault,
    output logic          pwm_hi,
    output logic          pwm_lo
);
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam logic [3:0]  A_CTRL    = 4'h0;
    localparam logic [3:0]  A_DT_RISE = 4'h4;
    localparam logic [3:0]  A_DT_FALL = 4'h8;
    localparam logic [3:0]  A_STATUS  = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_DEAD_R,
        S_HI,
        S_DEAD_F
    } state_e;

    state_e            state_q, state_d;
    logic [DT_W-1:0]   cnt_q, cnt_d;
    logic [DT_W-1:0]   dt_rise_q, dt_rise_d;
    logic [DT_W-1:0]   dt_fall_q, dt_fall_d;
    logic              en_q, en_d;
    logic              pol_hi_q, pol_hi_d;
    logic              pol_lo_q, pol_lo_d;
    logic              fault_flag_q, fault_flag_d;
    logic              sync1_q, sync1_d;
    logic              fault_s_q, fault_s_d;
    logic              pwm_hi_q, pwm_hi_d;
    logic              pwm_lo_q, pwm_lo_d;

    logic [3:0]        addr_lo;
    logic              wr_ctrl, wr_rise, wr_fall, wr_stat;
    logic [DT_W-1:0]   n_rise, n_fall;
    logic              cnt_done;
    logic              override;
    logic              unused_bus;

    assign addr_lo    = bus.bus_addr[3:0];
    assign wr_ctrl    = bus.bus_we && (addr_lo == A_CTRL);
    assign wr_rise    = bus.bus_we && (addr_lo == A_DT_RISE);
    assign wr_fall    = bus.bus_we && (addr_lo == A_DT_FALL);
    assign wr_stat    = bus.bus_we && (addr_lo == A_STATUS);
    assign unused_bus = ^{bus.bus_addr[ADDR_W-1:4], bus.bus_wdata};

    // A zero dead time still yields one both-off cycle so the outputs can never overlap.
    assign n_rise   = (dt_rise_q == '0) ? DT_W'(1) : dt_rise_q;
    assign n_fall   = (dt_fall_q == '0) ? DT_W'(1) : dt_fall_q;
    assign cnt_done = (cnt_q <= DT_W'(1));
    assign override = !en_q || fault_flag_q || fault_s_q;

    // Register file writes, fault synchroniser and sticky fault flag (set beats clear).
    always_comb begin
        en_d         = en_q;
        pol_hi_d     = pol_hi_q;
        pol_lo_d     = pol_lo_q;
        dt_rise_d    = dt_rise_q;
        dt_fall_d    = dt_fall_q;
        fault_flag_d = fault_flag_q;
        sync1_d      = fault;
        fault_s_d    = sync1_q;
        if (wr_ctrl) begin
            en_d     = bus.bus_wdata[0];
            pol_hi_d = bus.bus_wdata[1];
            pol_lo_d = bus.bus_wdata[2];
        end
        if (wr_rise) dt_rise_d = bus.bus_wdata[DT_W-1:0];
        if (wr_fall) dt_fall_d = bus.bus_wdata[DT_W-1:0];
        if (wr_stat && bus.bus_wdata[0]) fault_flag_d = 1'b0;
        if (fault_s_q) fault_flag_d = 1'b1;
    end

    // Next-state, dead-time counter and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (override) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pwm_in) begin
                        state_d = S_DEAD_R;
                        cnt_d   = n_rise;
                    end else begin
                        state_d = S_DEAD_F;
                        cnt_d   = n_fall;
                    end
                end
                S_LO: begin
                    if (pwm_in) begin
                        state_d = S_DEAD_R;
                        cnt_d   = n_rise;
                    end
                end
                S_DEAD_R: begin
                    if (!pwm_in)       state_d = S_LO;
                    else if (cnt_done) state_d = S_HI;
                    else               cnt_d   = cnt_q - DT_W'(1);
                end
                S_HI: begin
                    if (!pwm_in) begin
                        state_d = S_DEAD_F;
                        cnt_d   = n_fall;
                    end
                end
                S_DEAD_F: begin
                    if (pwm_in)        state_d = S_HI;
                    else if (cnt_done) state_d = S_LO;
                    else               cnt_d   = cnt_q - DT_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
        pwm_hi_d = (state_d == S_HI) ^ pol_hi_q;
        pwm_lo_d = (state_d == S_LO) ^ pol_lo_q;
    end

    // All state; reset forces both outputs low (inactive at reset polarity) immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dt_rise_q    <= '0;
            dt_fall_q    <= '0;
            en_q         <= 1'b0;
            pol_hi_q     <= 1'b0;
            pol_lo_q     <= 1'b0;
            fault_flag_q <= 1'b0;
            sync1_q      <= 1'b0;
            fault_s_q    <= 1'b0;
            pwm_hi_q     <= 1'b0;
            pwm_lo_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dt_rise_q    <= dt_rise_d;
            dt_fall_q    <= dt_fall_d;
            en_q         <= en_d;
            pol_hi_q     <= pol_hi_d;
            pol_lo_q     <= pol_lo_d;
            fault_flag_q <= fault_flag_d;
            sync1_q      <= sync1_d;
            fault_s_q    <= fault_s_d;
            pwm_hi_q     <= pwm_hi_d;
            pwm_lo_q     <= pwm_lo_d;
        end
    end

    assign pwm_hi = pwm_hi_q;
    assign pwm_lo = pwm_lo_q;

    // Combinational register read-back.
    always_comb begin
        bus.bus_rdata = '0;
        case (addr_lo)
            A_CTRL:    bus.bus_rdata = DATA_W'({pol_lo_q, pol_hi_q, en_q});
            A_DT_RISE: bus.bus_rdata = DATA_W'(dt_rise_q);
            A_DT_FALL: bus.bus_rdata = DATA_W'(dt_fall_q);
            A_STATUS:  bus.bus_rdata = DATA_W'({state_q == S_LO, state_q == S_HI,
                                                fault_s_q, fault_flag_q});
            default:   bus.bus_rdata = '0;
        endcase
    end
endmodule
